// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a hard-decision Viterbi decoder: steps the ACS datapath one
// symbol at a time, then traces back through survivor memory and hands out the frame.
module viterbi_frame_ctrl #(
  parameter int K         = 3,
  parameter int FRAME_LEN = 15,
  parameter int ADDR_W    = 4,
  localparam int M        = K - 1,
  localparam int NS       = 1 << M
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [1:0]           sym_in,
  output logic                 acs_init,
  output logic                 acs_en,
  output logic [1:0]           acs_sym,
  output logic                 surv_wr_en,
  output logic [ADDR_W-1:0]    surv_wr_addr,
  input  logic [M-1:0]         best_state,
  output logic                 surv_rd_en,
  output logic [ADDR_W-1:0]    surv_rd_addr,
  input  logic [NS-1:0]        surv_rd_data,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [FRAME_LEN-1:0] dec_data,
  output logic                 busy
);

  typedef enum logic [2:0] {INIT, ACS, FLUSH, SEL, TB, OUT} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] PEN_IDX  = ADDR_W'(FRAME_LEN - 2);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    symCnt_q, symCnt_d;
  logic [ADDR_W-1:0]    tbCnt_q, tbCnt_d;
  logic [M-1:0]         tbState_q, tbState_d;
  logic [FRAME_LEN-1:0] decData_q, decData_d;
  logic                 symReady_q, symReady_d;
  logic                 acsInit_q, acsInit_d;
  logic                 acsEn_q, acsEn_d;
  logic [1:0]           acsSym_q, acsSym_d;
  logic [ADDR_W-1:0]    wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0]    rdAddr_q, rdAddr_d;
  logic                 rdEn_q, rdEn_d;
  logic                 decValid_q, decValid_d;
  logic                 busy_q, busy_d;
  logic                 symHs, decHs;

  assign symHs = sym_valid && symReady_q;
  assign decHs = dec_ready && decValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = ACS;
      ACS:     if (symHs && symCnt_q == LAST_IDX) state_d = FLUSH;
      FLUSH:   state_d = SEL;
      SEL:     state_d = TB;
      TB:      if (tbCnt_q == LAST_IDX) state_d = OUT;
      OUT:     if (decHs) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Every output is a flop, so the values computed here describe the next cycle.
  always_comb begin
    symCnt_d   = symCnt_q;
    tbCnt_d    = tbCnt_q;
    tbState_d  = tbState_q;
    decData_d  = decData_q;
    acsInit_d  = (state_q == INIT);
    acsEn_d    = 1'b0;
    acsSym_d   = acsSym_q;
    wrAddr_d   = wrAddr_q;
    rdEn_d     = 1'b0;
    rdAddr_d   = rdAddr_q;
    symReady_d = (state_d == ACS);
    decValid_d = (state_d == OUT);
    case (state_q)
      INIT: symCnt_d = '0;
      ACS: begin
        if (symHs) begin
          acsEn_d  = 1'b1;
          acsSym_d = sym_in;
          wrAddr_d = symCnt_q;
          symCnt_d = (symCnt_q == LAST_IDX) ? '0 : symCnt_q + 1'b1;
        end
      end
      FLUSH: begin
        rdEn_d   = 1'b1;
        rdAddr_d = LAST_IDX;
      end
      SEL: begin
        tbState_d = best_state;
        tbCnt_d   = '0;
        rdEn_d    = 1'b1;
        rdAddr_d  = PEN_IDX;
      end
      TB: begin
        // Step to the predecessor: shift the surviving decision in at the LSB.
        decData_d[LAST_IDX - tbCnt_q] = tbState_q[M-1];
        tbState_d = M'({tbState_q, surv_rd_data[tbState_q]});
        tbCnt_d   = (tbCnt_q == LAST_IDX) ? '0 : tbCnt_q + 1'b1;
        if (tbCnt_q < PEN_IDX) begin
          rdEn_d   = 1'b1;
          rdAddr_d = rdAddr_q - 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = !((state_d == ACS) && (symCnt_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      symCnt_q   <= '0;
      tbCnt_q    <= '0;
      tbState_q  <= '0;
      decData_q  <= '0;
      symReady_q <= 1'b0;
      acsInit_q  <= 1'b0;
      acsEn_q    <= 1'b0;
      acsSym_q   <= '0;
      wrAddr_q   <= '0;
      rdAddr_q   <= '0;
      rdEn_q     <= 1'b0;
      decValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      symCnt_q   <= symCnt_d;
      tbCnt_q    <= tbCnt_d;
      tbState_q  <= tbState_d;
      decData_q  <= decData_d;
      symReady_q <= symReady_d;
      acsInit_q  <= acsInit_d;
      acsEn_q    <= acsEn_d;
      acsSym_q   <= acsSym_d;
      wrAddr_q   <= wrAddr_d;
      rdAddr_q   <= rdAddr_d;
      rdEn_q     <= rdEn_d;
      decValid_q <= decValid_d;
      busy_q     <= busy_d;
    end
  end

  assign sym_ready    = symReady_q;
  assign acs_init     = acsInit_q;
  assign acs_en       = acsEn_q;
  assign acs_sym      = acsSym_q;
  assign surv_wr_en   = acsEn_q;
  assign surv_wr_addr = wrAddr_q;
  assign surv_rd_en   = rdEn_q;
  assign surv_rd_addr = rdAddr_q;
  assign dec_valid    = decValid_q;
  assign dec_data     = decData_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: survivor memory model, randomized frames and a
// traceback reference computed directly from the decision vectors.
module tb_viterbi_frame_ctrl;

  localparam int K  = 3;
  localparam int M  = K - 1;
  localparam int NS = 1 << M;
  localparam int FL = 15;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sym_valid;
  logic          sym_ready;
  logic [1:0]    sym_in;
  logic          acs_init;
  logic          acs_en;
  logic [1:0]    acs_sym;
  logic          surv_wr_en;
  logic [AW-1:0] surv_wr_addr;
  logic [M-1:0]  best_state;
  logic          surv_rd_en;
  logic [AW-1:0] surv_rd_addr;
  logic [NS-1:0] surv_rd_data;
  logic          dec_valid;
  logic          dec_ready;
  logic [FL-1:0] dec_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [NS-1:0] survMem [1 << AW];
  logic [NS-1:0] decSeq  [FL];
  logic [NS-1:0] curDec;

  viterbi_frame_ctrl #(.K(K), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym_in       (sym_in),
    .acs_init     (acs_init),
    .acs_en       (acs_en),
    .acs_sym      (acs_sym),
    .surv_wr_en   (surv_wr_en),
    .surv_wr_addr (surv_wr_addr),
    .best_state   (best_state),
    .surv_rd_en   (surv_rd_en),
    .surv_rd_addr (surv_rd_addr),
    .surv_rd_data (surv_rd_data),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_data     (dec_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Survivor memory: the datapath's decision vector is written alongside acs_en,
  // reads return one cycle after the strobe.
  always @(posedge clk) begin
    if (surv_wr_en) survMem[surv_wr_addr] <= curDec;
    if (surv_rd_en) surv_rd_data <= survMem[surv_rd_addr];
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int outsVec();
    return int'({sym_ready, acs_init, acs_en, acs_sym, surv_wr_en, surv_wr_addr,
                 surv_rd_en, surv_rd_addr, dec_valid, dec_data, busy});
  endfunction

  // Walk back from the best state: emit its newest bit, then move to the predecessor.
  function automatic logic [FL-1:0] refDecode(input int best);
    int s;
    logic [FL-1:0] bits;
    s    = best;
    bits = '0;
    for (int t = FL - 1; t >= 0; t--) begin
      bits[t] = s[M-1];
      s = ((s << 1) | int'(decSeq[t][s])) % NS;
    end
    return bits;
  endfunction

  // decMode: 0 all-0, 1 all-1, 2 random; gapMode: 0 back-to-back, 1 toggle, 2 random;
  // symMode: 0 random, 1 all 2'b11; abortAt >= 0 asserts reset at that traceback step.
  task automatic applyStimulus(input int decMode, input int bestSel, input int gapMode,
                               input int symMode, input int stall, input int abortAt);
    logic [FL-1:0] expData, heldData;
    logic [1:0]    syms [FL];
    int  sent, acsCount, rdCount, initCount, cyc, lastHsCyc, stallLeft, bsPhase;
    bit  hsPrev, decHsPrev, prevInit, done, seenValid, toggle, offer;

    for (int t = 0; t < FL; t++) begin
      decSeq[t] = (decMode == 0) ? '0 : (decMode == 1) ? '1 : NS'($urandom);
      syms[t]   = (symMode == 1) ? 2'b11 : 2'($urandom);
    end
    expData   = refDecode(bestSel);
    heldData  = '0;
    sent      = 0;
    acsCount  = 0;
    rdCount   = 0;
    initCount = 0;
    cyc       = 0;
    lastHsCyc = -1;
    stallLeft = stall;
    bsPhase   = 0;
    hsPrev    = 1'b0;
    decHsPrev = 1'b0;
    prevInit  = 1'b0;
    done      = 1'b0;
    seenValid = 1'b0;
    toggle    = 1'b1;

    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checkOutput("acs_en", int'(acs_en), int'(hsPrev));
      checkOutput("wr_en_eq", int'(surv_wr_en), int'(acs_en));
      if (acs_en) begin
        if (acsCount < FL) begin
          checkOutput("acs_sym", int'(acs_sym), int'(syms[acsCount]));
          checkOutput("wr_addr", int'(surv_wr_addr), acsCount);
          if (gapMode == 0 && acsCount == 0) checkOutput("init_lead", int'(prevInit), 1);
          curDec = decSeq[acsCount];
        end else begin
          checkOutput("acs_extra", acsCount, FL - 1);
        end
        acsCount++;
        if (acsCount == FL) bsPhase = 2;
      end
      if (acs_init) initCount++;
      if (surv_rd_en) begin
        checkOutput("rd_wr_excl", int'(surv_wr_en), 0);
        checkOutput("rd_addr", int'(surv_rd_addr), FL - 1 - rdCount);
        checkOutput("busy_tb", int'(busy), 1);
        rdCount++;
      end
      if (lastHsCyc >= 0) checkOutput("ready_low", int'(sym_ready), 0);
      if (sym_ready && acsCount == 0) checkOutput("busy_idle", int'(busy), 0);
      if (seenValid) begin
        checkOutput("dec_valid_hold", int'(dec_valid), int'(!decHsPrev));
        if (dec_valid) checkOutput("dec_stable", int'(dec_data), int'(heldData));
        else done = 1'b1;
      end else if (dec_valid) begin
        seenValid = 1'b1;
        checkOutput("latency", cyc - lastHsCyc, FL + 3);
        checkOutput("acs_cnt", acsCount, FL);
        checkOutput("rd_cnt", rdCount, FL);
        checkOutput("init_cnt", initCount, 1);
        checkOutput("dec_data", int'(dec_data), int'(expData));
        checkOutput("busy_out", int'(busy), 1);
        heldData = dec_data;
      end

      if (abortAt >= 0 && lastHsCyc >= 0 && cyc == lastHsCyc + 3 + abortAt) begin
        checkOutput("abort_rd", rdCount, abortAt + 2);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_clear", outsVec(), 0);
        done = 1'b1;
      end

      if (!done) begin
        if (sent < FL) begin
          case (gapMode)
            0:       offer = 1'b1;
            1:       begin offer = toggle; toggle = !toggle; end
            default: offer = 1'($urandom_range(0, 1));
          endcase
          sym_valid = offer;
          sym_in    = offer ? syms[sent] : 2'($urandom);
        end else begin
          sym_valid = (gapMode != 1);
          sym_in    = 2'($urandom);
        end
        hsPrev = sym_valid && sym_ready;
        if (hsPrev && sent < FL) begin
          sent++;
          if (sent == FL) lastHsCyc = cyc;
        end

        if (bsPhase == 1) best_state = M'(bestSel);
        else              best_state = M'(bestSel) ^ M'($urandom_range(1, NS - 1));
        if (bsPhase > 0) bsPhase--;

        if (dec_valid) begin
          if (stallLeft > 0) begin
            dec_ready = 1'b0;
            stallLeft--;
          end else begin
            dec_ready = 1'b1;
          end
        end else begin
          dec_ready = 1'($urandom_range(0, 1));
        end
        decHsPrev = dec_valid && dec_ready;
        prevInit  = acs_init;
      end
    end
    if (!done) checkOutput("timeout", cyc, -1);
  endtask

  task automatic holdReset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", outsVec(), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    sym_valid  = 1'b0;
    sym_in     = '0;
    dec_ready  = 1'b0;
    best_state = '0;
    curDec     = '0;
    holdReset();

    applyStimulus(0, 0, 0, 0, 0, -1);
    applyStimulus(0, 2, 0, 0, 0, -1);
    applyStimulus(1, 3, 0, 0, 0, -1);
    applyStimulus(2, $urandom_range(0, NS - 1), 1, 0, 5, -1);
    applyStimulus(2, 1, 0, 0, 0, 7);
    holdReset();
    applyStimulus(2, $urandom_range(0, NS - 1), 0, 1, 0, -1);
    for (int f = 0; f < 8; f++)
      applyStimulus(2, $urandom_range(0, NS - 1), 2, 0, $urandom_range(0, 4), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the hard-decision Viterbi decoder. It accepts encoded symbol pairs through a valid/ready handshake and drives the add-compare-select (ACS) datapath one symbol per step, writing that datapath's survivor decisions into survivor memory. After each frame it runs traceback through survivor memory from the datapath's best state and returns the decoded frame through a valid/ready output handshake. It sits between the symbol source and the ACS/path-metric datapath; metric arithmetic stays in the datapath.

Parameters:
K, 3, constraint length; M = K-1 is the state width, NS = 2^M is the number of states.
FRAME_LEN, 15, symbols per frame and traceback length; 2..2^ADDR_W.
ADDR_W, 4, survivor memory address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
sym_valid  in  1  encoded symbol available.
sym_ready  out  1  controller accepts a symbol.
sym_in  in  2  encoded pair, bit1 = first coded bit.
acs_init  out  1  one-cycle pulse: datapath loads start metrics (state 0 = 0, others maximum).
acs_en  out  1  datapath performs one ACS step on acs_sym.
acs_sym  out  2  registered copy of the accepted sym_in.
surv_wr_en  out  1  write the datapath decision vector; equals acs_en.
surv_wr_addr  out  ADDR_W  symbol index within the frame.
best_state  in  M  minimum-metric state from the datapath; valid the cycle after the last acs_en.
surv_rd_en  out  1  survivor read strobe.
surv_rd_addr  out  ADDR_W  survivor read address.
surv_rd_data  in  NS  decision bits for all states; synchronous memory with 1-cycle read latency.
dec_valid  out  1  decoded frame available.
dec_ready  in  1  consumer accepts the frame.
dec_data  out  FRAME_LEN  decoded bits; bit i = symbol i, bit 0 = first symbol.
busy  out  1  high in every state except ACS with sym_cnt = 0.

Behaviour:
- All outputs are registered. Reset (asynchronous) clears every output and counter to 0 and sets FSM = INIT.
- State convention:
  - state = {u_t, u_t-1, ...}, with the newest input in the MSB.
  - The predecessor of state s with decision d is {s[M-2:0], d}.
  - The decoded bit at step t is s[M-1].
- INIT:
  - acs_init = 1 for one cycle.
  - sym_cnt = 0.
  - Next state is ACS.
- ACS:
  - sym_ready = 1.
  - On a handshake (sym_valid and sym_ready) in cycle c, in cycle c+1: acs_en = 1, surv_wr_en = 1, acs_sym = sym_in, surv_wr_addr = sym_cnt. sym_cnt then increments.
  - Without a handshake, acs_en = 0 and sym_cnt holds. Gaps in sym_valid are legal.
  - On the handshake with sym_cnt = FRAME_LEN-1, sym_ready drops the next cycle and the FSM moves to FLUSH.
- FLUSH:
  - One cycle carrying the final acs_en/surv_wr_en.
  - sym_ready = 0.
- SEL:
  - Latch tb_state = best_state.
  - surv_rd_en = 1, surv_rd_addr = FRAME_LEN-1.
- TB (runs FRAME_LEN cycles, j = 0..FRAME_LEN-1):
  - surv_rd_data holds the decisions for address FRAME_LEN-1-j.
  - dec_data[FRAME_LEN-1-j] <= tb_state[M-1].
  - tb_state <= {tb_state[M-2:0], surv_rd_data[tb_state]}.
  - surv_rd_en = 1 with address FRAME_LEN-2-j for j < FRAME_LEN-1; surv_rd_en = 0 at j = FRAME_LEN-1.
- OUT:
  - dec_valid = 1 and dec_data is stable until dec_ready.
  - On the handshake, dec_valid drops the next cycle and the FSM moves to INIT.
  - dec_ready while dec_valid = 0 is ignored.
- Latency: the last symbol handshake in cycle c gives dec_valid = 1 in cycle c+FRAME_LEN+3. Frames do not overlap.
- Boundaries:
  - sym_cnt and read addresses never exceed FRAME_LEN-1.
  - sym_valid outside ACS is held off with sym_ready = 0, never dropped.
  - surv_wr_en and surv_rd_en are never high in the same cycle.
- Reset in any state, including mid-TB or OUT: outputs clear immediately. The partial frame is discarded. The next frame starts with INIT after rst_n rises.

Test Plan:
- Reset release, FRAME_LEN = 15, 15 back-to-back symbols -> acs_init one cycle before the first acs_en; surv_wr_addr 0..14; dec_valid 18 cycles after the last handshake.
- Memory model returns all-0 decisions, best_state = 2'b00 -> dec_data = 15'h0000.
- All-0 decisions, best_state = 2'b10 -> dec_data = 15'h4000; read addresses 14 down to 0 strictly.
- All-1 decisions, best_state = 2'b11 -> dec_data = 15'h7FFF.
- sym_valid toggling every other cycle, with dec_ready held low 5 cycles in OUT -> acs_en count = 15; dec_data stable through the stall; sym_ready = 0 from FLUSH to INIT.
- Reset asserted at TB j = 7, then a full frame of sym_in = 2'b11 from the encoder golden model -> outputs 0 during reset; the new frame decodes correctly; no residue from the aborted frame.
